// File: rtl/tensor_stream.sv
// tensor_stream: streams a 4x4 boolean matrix job (A, B, optional C) in as
// 4-bit row beats, presents the operands to an external combinational
// boolean MAC core (OUT = (A.B) OR C), captures the core result and streams
// it back out as four row beats.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input row handshake; in_data = one row (bit c = col c)
//   chain               sampled on the last B beat: 1 = C := previous result
//   a_flat/b_flat/c_flat operands to the core, row-major (r*4+c)
//   out_flat            core result
//   out_valid/out_ready output row handshake; out_data = result row,
//                       out_last marks row 3
//   busy                high except when idle in LOAD at beat 0
//   jobs_done           completed-job counter, wraps 255->0

// Per-row operand storage: one instance per matrix row holds that row of
// A, B and C.  C may instead be loaded from the previous result (chaining).
module ts_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       we_a,
  input  logic       we_b,
  input  logic       we_c,
  input  logic       ld_c,
  input  logic [3:0] din,
  input  logic [3:0] res_row,
  output logic [3:0] a_row,
  output logic [3:0] b_row,
  output logic [3:0] c_row
);
  always_ff @(posedge clk) begin
    if (rst) begin
      a_row <= '0;
      b_row <= '0;
      c_row <= '0;
    end else begin
      if (we_a) a_row <= din;
      if (we_b) b_row <= din;
      if (we_c)      c_row <= din;
      else if (ld_c) c_row <= res_row;
    end
  end
endmodule

module tensor_stream #(
  parameter int NUM_LANES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  input  logic        chain,
  output logic [15:0] a_flat,
  output logic [15:0] b_flat,
  output logic [15:0] c_flat,
  input  logic [15:0] out_flat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  jobs_done
);
  typedef enum logic [1:0] {LOAD, CAPTURE, SEND} state_t;

  state_t state, state_nxt;
  logic [3:0] bidx;
  logic [1:0] ridx;
  logic [NUM_LANES-1:0][3:0] a_q, b_q, c_q, res;
  logic in_fire, out_fire, chain_end, last_beat, last_row;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign chain_end = in_fire & (bidx == 4'd7) & chain;
  assign last_beat = in_fire & ((bidx == 4'd11) | ((bidx == 4'd7) & chain));
  assign last_row  = out_fire & (ridx == 2'd3);

  // operand lanes; packed [row][col] maps straight onto row-major flat buses
  for (genvar r = 0; r < NUM_LANES; r++) begin : g_lane
    ts_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .we_a    (in_fire & (bidx == 4'(r))),
      .we_b    (in_fire & (bidx == 4'(r + 4))),
      .we_c    (in_fire & (bidx == 4'(r + 8))),
      .ld_c    (chain_end),
      .din     (in_data),
      .res_row (res[r]),
      .a_row   (a_q[r]),
      .b_row   (b_q[r]),
      .c_row   (c_q[r])
    );
  end

  assign a_flat = a_q;
  assign b_flat = b_q;
  assign c_flat = c_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (last_beat) state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (last_row) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // outputs; in_ready is gated by rst so nothing is accepted during reset
  always_comb begin
    in_ready  = (state == LOAD) & ~rst;
    out_valid = (state == SEND);
    out_data  = (state == SEND) ? res[ridx] : 4'd0;
    out_last  = (state == SEND) & (ridx == 2'd3);
    busy      = !((state == LOAD) && (bidx == 4'd0));
  end

  // datapath counters and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      bidx      <= '0;
      ridx      <= '0;
      res       <= '0;
      jobs_done <= '0;
    end else begin
      if (last_beat)    bidx <= '0;
      else if (in_fire) bidx <= bidx + 4'd1;
      if (out_fire) ridx <= ridx + 2'd1;  // wraps 3->0 at end of job
      if (state == CAPTURE) res <= out_flat;
      if (last_row) jobs_done <= jobs_done + 8'd1;
    end
  end
endmodule

// File: tb/tb_tensor_stream.sv
module tb_tensor_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = '0;
  logic        chain = 1'b0;
  logic [15:0] a_flat, b_flat, c_flat, out_flat;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic        out_last;
  logic        busy;
  logic [7:0]  jobs_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tensor_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .chain(chain), .a_flat(a_flat), .b_flat(b_flat),
    .c_flat(c_flat), .out_flat(out_flat), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .jobs_done(jobs_done)
  );

  // external boolean MAC core: OUT(r,c) = OR_k A(r,k)&B(k,c) | C(r,c)
  always_comb begin
    out_flat = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        out_flat[r*4+c] = c_flat[r*4+c];
        for (int k = 0; k < 4; k++)
          out_flat[r*4+c] = out_flat[r*4+c] | (a_flat[r*4+k] & b_flat[k*4+c]);
      end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // one input beat; called and returns at a negedge
  task automatic push(input logic [3:0] d, input logic ch);
    int n = 0;
    in_valid = 1'b1; in_data = d; chain = ch;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("push_timeout", 32'(n), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; in_data = 4'h0; chain = 1'b0;
  endtask

  // rows are nibbles of a 16-bit word, row 0 in bits 3:0
  task automatic run_job(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic ch);
    for (int i = 0; i < 4; i++) push(a[i*4+:4], 1'b0);
    for (int i = 0; i < 4; i++) push(b[i*4+:4], (i == 3) ? ch : 1'b0);
    if (!ch) for (int i = 0; i < 4; i++) push(c[i*4+:4], 1'b0);
    chk("cap_in_ready", 32'(in_ready), 32'd0);
    chk("cap_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic pull_rows(input string tag, input logic [15:0] exp);
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), 32'(n), 32'd0);
      chk($sformatf("%s_vld%0d", tag, i), 32'(out_valid), 32'd1);
      chk($sformatf("%s_row%0d", tag, i), 32'(out_data), 32'(exp[i*4+:4]));
      chk($sformatf("%s_last%0d", tag, i), 32'(out_last), (i == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk($sformatf("%s_back_to_load", tag), 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_a_flat", 32'(a_flat), 32'd0);
    chk("rst_b_flat", 32'(b_flat), 32'd0);
    chk("rst_c_flat", 32'(c_flat), 32'd0);
    chk("rst_jobs", 32'(jobs_done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
  endtask

  localparam logic [15:0] A_ID  = 16'h8421;  // rows 1,2,4,8
  localparam logic [15:0] B_ID  = 16'hF953;  // rows 3,5,9,F

  initial begin
    do_reset();

    // identity
    run_job(A_ID, B_ID, 16'h0000, 1'b0);
    pull_rows("ident", 16'hF953);
    chk("ident_jobs", 32'(jobs_done), 32'd1);

    // chain reuses previous result as C
    run_job(16'h0000, 16'h0000, 16'h0000, 1'b1);
    chk("chain_c_flat", 32'(c_flat), 32'hF953);
    pull_rows("chain", 16'hF953);
    chk("chain_jobs", 32'(jobs_done), 32'd2);

    // C passthrough: rows A,5,0,F
    run_job(16'h0000, 16'hFFFF, 16'hF05A, 1'b0);
    pull_rows("cpass", 16'hF05A);

    // column OR
    run_job(16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    pull_rows("color", 16'h1111);
    chk("color_jobs", 32'(jobs_done), 32'd4);

    // backpressure in SEND
    run_job(A_ID, B_ID, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_vld%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_data%0d", i), 32'(out_data), 32'h3);
      chk($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    pull_rows("bp", 16'hF953);
    chk("bp_jobs", 32'(jobs_done), 32'd5);
    chk("bp_hold_a", 32'(a_flat), 32'(A_ID));

    // chained job straight after reset sees C=0
    do_reset();
    run_job(16'h0000, 16'h0000, 16'h0000, 1'b1);
    chk("rchain_c_flat", 32'(c_flat), 32'd0);
    pull_rows("rchain", 16'h0000);
    chk("rchain_jobs", 32'(jobs_done), 32'd1);

    // reset in the middle of a load discards the partial job
    for (int i = 0; i < 4; i++) push(A_ID[i*4+:4], 1'b0);
    push(4'h3, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_a_flat", 32'(a_flat), 32'(A_ID));
    chk("mid_b_flat", 32'(b_flat), 32'h0003);
    do_reset();
    run_job(A_ID, B_ID, 16'h0000, 1'b0);
    pull_rows("post", 16'hF953);
    chk("post_jobs", 32'(jobs_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
